// File: rtl/io_bridge.sv
// io_bridge: CPU output port to device TX FIFO, plus a single-word device RX holding register.
// Ports:
//   clk, reset (async active-low)
//   outport_enable/outport_data   CPU write into the TX FIFO
//   inport_in/inport_valid/in_ack CPU view of the RX holding register
//   dev_tx_data/valid/ready       device transmit handshake (FIFO head)
//   dev_rx_data/valid/ready       device receive handshake
//   tx_count                      TX FIFO occupancy
//   overflow/ovf_clr              sticky dropped-write flag and its clear
module io_bridge #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     outport_enable,
    input  logic [31:0]              outport_data,
    output logic [31:0]              inport_in,
    output logic                     inport_valid,
    input  logic                     in_ack,
    output logic [31:0]              dev_tx_data,
    output logic                     dev_tx_valid,
    input  logic                     dev_tx_ready,
    input  logic [31:0]              dev_rx_data,
    input  logic                     dev_rx_valid,
    output logic                     dev_rx_ready,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {EMPTY, HOLD} rx_state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, push, pop, drop;
    rx_state_e     st_q, st_d;
    logic [31:0]   in_q, in_d;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        full  = cnt_q == CW'(DEPTH);
        pop   = (cnt_q != '0) && dev_tx_ready;
        push  = outport_enable && (!full || pop);
        drop  = outport_enable && !push;
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
        ovf_d = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage is cleared on reset so dev_tx_data reads zero while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q] <= outport_data;
        end
    end

    // RX: capture only from EMPTY, so an ack in HOLD always spends one cycle in EMPTY.
    always_comb begin
        st_d = (st_q == EMPTY) ? (dev_rx_valid ? HOLD : EMPTY) : (in_ack ? EMPTY : HOLD);
        in_d = (st_q == EMPTY && dev_rx_valid) ? dev_rx_data : in_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= EMPTY;
            in_q <= '0;
        end else begin
            st_q <= st_d;
            in_q <= in_d;
        end
    end

    assign dev_tx_data  = mem_q[rd_q];
    assign dev_tx_valid = cnt_q != '0;
    assign tx_count     = cnt_q;
    assign overflow     = ovf_q;
    assign inport_in    = in_q;
    assign inport_valid = st_q == HOLD;
    assign dev_rx_ready = st_q == EMPTY;
endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the TX FIFO depth in words; legal values are powers of two, 2..16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port outport_enable, input, 1 bit: one-cycle CPU write strobe to the output port.
REQ-005 The module SHALL have port outport_data, input, 32 bits: the word written by the CPU, sampled when outport_enable=1.
REQ-006 The module SHALL have port inport_in, output, 32 bits: the device word presented to the CPU input port.
REQ-007 The module SHALL have port inport_valid, output, 1 bit: inport_in holds an unconsumed device word.
REQ-008 The module SHALL have port in_ack, input, 1 bit: one-cycle CPU pulse that consumes the current inport word.
REQ-009 The module SHALL have ports dev_tx_data (output, 32), dev_tx_valid (output, 1) and dev_tx_ready (input, 1): the device-side transmit handshake.
REQ-010 The module SHALL have ports dev_rx_data (input, 32), dev_rx_valid (input, 1) and dev_rx_ready (output, 1): the device-side receive handshake.
REQ-011 The module SHALL have port tx_count, output, clog2(DEPTH)+1 bits: current TX FIFO occupancy.
REQ-012 The module SHALL have port overflow, output, 1 bit: sticky flag set when a CPU write is dropped.
REQ-013 The module SHALL have port ovf_clr, input, 1 bit: one-cycle pulse that clears overflow.

Function
REQ-014 TX push SHALL occur when outport_enable=1 and the FIFO is not full, or when the FIFO is full and a pop occurs in the same cycle.
REQ-015 TX pop SHALL occur when dev_tx_valid=1 and dev_tx_ready=1.
REQ-016 Push and pop SHALL each take effect at the rising edge; read and write pointers SHALL wrap modulo DEPTH.
REQ-017 On a simultaneous push and pop, tx_count SHALL be unchanged.
REQ-018 dev_tx_valid SHALL equal (tx_count != 0) and SHALL be driven from registers only.
REQ-019 dev_tx_data SHALL be the head entry and SHALL remain stable while dev_tx_valid=1 and dev_tx_ready=0.
REQ-020 A word pushed at edge N SHALL appear on dev_tx_data with dev_tx_valid=1 immediately after edge N, when the FIFO was empty.
REQ-021 A push attempt that is refused (full, no same-cycle pop) SHALL discard the word, leave the FIFO unchanged, and set overflow at that edge.
REQ-022 ovf_clr SHALL clear overflow; if a new drop occurs in the same cycle, the set SHALL win.
REQ-023 The RX path SHALL be a two-state FSM with states EMPTY and HOLD.
REQ-024 In EMPTY, dev_rx_ready SHALL be 1 and inport_valid SHALL be 0; when dev_rx_valid=1, the FSM SHALL capture dev_rx_data into inport_in and go to HOLD.
REQ-025 In HOLD, dev_rx_ready SHALL be 0 and inport_valid SHALL be 1; when in_ack=1, the FSM SHALL go to EMPTY.
REQ-026 dev_rx_ready and inport_valid SHALL be decoded from the state register only, with no combinational path from any input.
REQ-027 inport_in SHALL retain the last captured word after in_ack and SHALL change only on a capture.
REQ-028 in_ack while in EMPTY SHALL be ignored.
REQ-029 When in_ack=1 and dev_rx_valid=1 occur together in HOLD, the FSM SHALL go to EMPTY without capturing; the device word SHALL be accepted on the next cycle.
REQ-030 The RX path SHALL sustain at most one word per two cycles.
REQ-031 The TX and RX paths SHALL be fully independent.

Reset
REQ-032 While reset=0, the module SHALL empty the FIFO, reset both pointers to 0 and set tx_count=0.
REQ-033 While reset=0, outputs SHALL be dev_tx_valid=0, dev_tx_data=0, overflow=0, inport_in=0, inport_valid=0, RX FSM in EMPTY and dev_rx_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all queued TX words and any held RX word immediately, without waiting for a clock edge.
REQ-035 No state SHALL change on the first clock edge on which reset is already 1 unless a handshake is active in that cycle.

Verification
REQ-036 Scenario 1: write 0xA5A5_0001 with dev_tx_ready=0 -> dev_tx_valid=1, dev_tx_data=0xA5A5_0001, tx_count=1; this SHALL hold for 5 cycles; raise ready for 1 cycle -> tx_count=0.
REQ-037 Scenario 2: DEPTH=4, ready=0, write 1,2,3,4,5 -> tx_count=4, overflow=1; drain -> words 1,2,3,4 in order; pulse ovf_clr -> overflow=0.
REQ-038 Scenario 3: FIFO full with ready=1 and write 0x77 in the same cycle -> tx_count stays 4 and overflow stays 0; 0x77 SHALL be the last word drained.
REQ-039 Scenario 4: dev_rx_valid=1 with data 0x1234 held continuously -> inport_in=0x1234, inport_valid=1, dev_rx_ready=0; in_ack -> EMPTY, and the next word is captured one cycle later.
REQ-040 Scenario 5: push 3 words and capture an RX word, then assert reset=0 between edges -> tx_count=0, dev_tx_valid=0, inport_valid=0 and dev_rx_ready=1 immediately.
REQ-041 Scenario 6: run the pointers through 3 full wraps with random ready and write patterns -> the output stream SHALL match a reference queue model word for word.
